sw_debounce: RTL and testbench

//   Synchronises and debounces the raw DE0-Nano slide-switch inputs.

---
 rtl/sw_debounce_pkg.sv | 20 ++
 rtl/sw_debounce_bit.sv | 90 +++++++++
 rtl/sw_debounce.sv | 59 +++++
 tb/tb_sw_debounce.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sw_debounce_pkg.sv
// Shared defaults and helpers for the slide-switch debouncer.
//   SW_DEBOUNCE_CYCLES_DEFAULT : stability window in clk cycles (1 ms @ 50 MHz)
//   SW_CNT_W_DEFAULT           : stability counter width
//   sw_clog2()                 : ceil(log2(value)), used to validate CNT_W
package sw_debounce_pkg;

    localparam int unsigned SW_DEBOUNCE_CYCLES_DEFAULT = 50000;
    localparam int unsigned SW_CNT_W_DEFAULT           = 16;

    // Smallest n with 2**n >= value (0 for value <= 1).
    function automatic int unsigned sw_clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage : sw_debounce_pkg

// File: rtl/sw_debounce_bit.sv
// One debounced switch bit: 2-FF synchroniser, stability counter and
// accepted-level register. Optional edge pulses / sticky flag when
// SW_DEBOUNCE_EDGE_EN is defined.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   sw_raw       asynchronous switch pin
//   sw_out       debounced level
//   sw_rise      1-cycle pulse on accepted 0->1 (edge build only, else 0)
//   sw_fall      1-cycle pulse on accepted 1->0 (edge build only, else 0)
//   edge_flag    sticky changed flag (edge build only, else 0)
//   flag_clr     write-1-to-clear for edge_flag; set wins over clear
module sw_debounce_bit
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = SW_CNT_W_DEFAULT,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sw_raw,
    output logic sw_out,
    output logic sw_rise,
    output logic sw_fall,
    output logic edge_flag,
    input  logic flag_clr
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             out_d;
    logic             accept_c;

    // Counter value encodes the state: 0 while stable, counting while pending.
    always_comb begin
        cnt_d    = '0;
        out_d    = sw_out;
        accept_c = 1'b0;
        if (s2 != sw_out) begin
            if (cnt == CNT_LAST) begin
                accept_c = 1'b1;
                out_d    = s2;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    // Synchroniser, counter and accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1     <= RESET_VAL;
            s2     <= RESET_VAL;
            sw_out <= RESET_VAL;
            cnt    <= '0;
        end else begin
            s1     <= sw_raw;
            s2     <= s1;
            sw_out <= out_d;
            cnt    <= cnt_d;
        end
    end

`ifdef SW_DEBOUNCE_EDGE_EN
    // Pulses line up with the new sw_out value; a new edge beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sw_rise   <= 1'b0;
            sw_fall   <= 1'b0;
            edge_flag <= 1'b0;
        end else begin
            sw_rise   <= accept_c & s2;
            sw_fall   <= accept_c & ~s2;
            edge_flag <= accept_c | (edge_flag & ~flag_clr);
        end
    end
`else
    logic edge_unused;

    assign sw_rise     = 1'b0;
    assign sw_fall     = 1'b0;
    assign edge_flag   = 1'b0;
    assign edge_unused = flag_clr ^ accept_c;
`endif

endmodule : sw_debounce_bit

// File: rtl/sw_debounce.sv
// Synchronises and debounces the DE0-Nano slide switches; sw_out feeds the
// switch PIO in_port so software only sees clean levels.
// Optional edge detection is built when SW_DEBOUNCE_EDGE_EN is defined;
// otherwise sw_rise/sw_fall/edge_flag read 0 and flag_clr is ignored.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   sw_raw     [WIDTH] asynchronous switch pins
//   sw_out     [WIDTH] debounced levels
//   sw_rise    [WIDTH] accepted 0->1 pulses
//   sw_fall    [WIDTH] accepted 1->0 pulses
//   edge_flag  [WIDTH] sticky changed flags
//   flag_clr   [WIDTH] write-1-to-clear mask for edge_flag
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned      CNT_W           = SW_CNT_W_DEFAULT,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic [WIDTH-1:0] edge_flag,
    input  logic [WIDTH-1:0] flag_clr
);

    // Counter must reach DEBOUNCE_CYCLES-1 without wrapping.
    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
            $error("sw_debounce: DEBOUNCE_CYCLES must be >= 2");
        end
        if (CNT_W < sw_clog2(DEBOUNCE_CYCLES + 1)) begin : g_bad_cnt_w
            $error("sw_debounce: 2**CNT_W must exceed DEBOUNCE_CYCLES");
        end
    endgenerate

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .sw_raw    (sw_raw[i]),
            .sw_out    (sw_out[i]),
            .sw_rise   (sw_rise[i]),
            .sw_fall   (sw_fall[i]),
            .edge_flag (edge_flag[i]),
            .flag_clr  (flag_clr[i])
        );
    end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, WIDTH=4, RESET_VAL=0.
// Expected edge outputs are zero unless SW_DEBOUNCE_EDGE_EN is defined.
module tb_sw_debounce;

`ifdef SW_DEBOUNCE_EDGE_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] sw_out;
    logic [3:0] sw_rise;
    logic [3:0] sw_fall;
    logic [3:0] edge_flag;
    logic [3:0] flag_clr;

    int n_checks = 0;
    int n_fail   = 0;

    sw_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3),
        .RESET_VAL       (4'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .sw_out    (sw_out),
        .sw_rise   (sw_rise),
        .sw_fall   (sw_fall),
        .edge_flag (edge_flag),
        .flag_clr  (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] e(input logic [3:0] v);
        return EDGE ? v : 4'h0;
    endfunction

    // n cycles with sw_out held at exp and no edge pulses.
    task automatic hold(input int n, input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq({tag, "_out"}, 32'(sw_out), 32'(exp));
            check_eq({tag, "_rise"}, 32'(sw_rise), 32'h0);
            check_eq({tag, "_fall"}, 32'(sw_fall), 32'h0);
        end
    endtask

    task automatic clear_flags();
        flag_clr = 4'hF;
        tick();
        flag_clr = 4'h0;
        check_eq("flag_clear", 32'(edge_flag), 32'h0);
    endtask

    // Step sw_raw to v (from level old) and verify acceptance exactly 6 cycles later.
    task automatic step_to(input logic [3:0] v, input logic [3:0] old, input string tag);
        sw_raw = v;
        hold(5, old, tag);
        tick();
        check_eq({tag, "_accept"}, 32'(sw_out), 32'(v));
        check_eq({tag, "_rise_pulse"}, 32'(sw_rise), 32'(e(v & ~old)));
        check_eq({tag, "_fall_pulse"}, 32'(sw_fall), 32'(e(old & ~v)));
        tick();
        check_eq({tag, "_rise_end"}, 32'(sw_rise), 32'h0);
        check_eq({tag, "_fall_end"}, 32'(sw_fall), 32'h0);
    endtask

    initial begin
        reset    = 1'b1;
        sw_raw   = 4'hF;
        flag_clr = 4'h0;

        // 1. Reset held 3 cycles with all switches high.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_out", 32'(sw_out), 32'h0);
            check_eq("rst_rise", 32'(sw_rise), 32'h0);
            check_eq("rst_fall", 32'(sw_fall), 32'h0);
            check_eq("rst_flag", 32'(edge_flag), 32'h0);
        end
        reset = 1'b0;
        hold(5, 4'h0, "rel");
        tick();
        check_eq("rel_accept", 32'(sw_out), 32'hF);
        check_eq("rel_rise", 32'(sw_rise), 32'(e(4'hF)));
        check_eq("rel_flag", 32'(edge_flag), 32'(e(4'hF)));
        clear_flags();
        step_to(4'h0, 4'hF, "to0");
        clear_flags();

        // 2. Clean step to 4'h5.
        step_to(4'h5, 4'h0, "step5");
        check_eq("step5_flag", 32'(edge_flag), 32'(e(4'h5)));
        step_to(4'h0, 4'h5, "back0");
        clear_flags();

        // 3. Bounce on bit0, then hold high.
        for (int k = 0; k < 4; k++) begin
            sw_raw = (k % 2 == 0) ? 4'h1 : 4'h0;
            hold(2, 4'h0, "bounce");
        end
        step_to(4'h1, 4'h0, "bounce_hold");
        step_to(4'h0, 4'h1, "bounce_back");
        clear_flags();

        // 4. Three-cycle glitch on bit3 never propagates.
        sw_raw = 4'h8;
        hold(3, 4'h0, "glitch");
        sw_raw = 4'h0;
        hold(8, 4'h0, "glitch_after");
        check_eq("glitch_flag", 32'(edge_flag), 32'h0);

        // 5. Reset during a pending count discards it.
        sw_raw = 4'h2;
        hold(4, 4'h0, "midcnt");
        reset = 1'b1;
        hold(1, 4'h0, "midrst");
        check_eq("midrst_flag", 32'(edge_flag), 32'h0);
        reset = 1'b0;
        step_to(4'h2, 4'h0, "midrel");
        check_eq("midrel_flag", 32'(edge_flag), 32'(e(4'h2)));
        clear_flags();

        // 6. Set beats clear on the same cycle; a later clear works.
        step_to(4'h3, 4'h2, "f_rise");
        check_eq("f_flag_set", 32'(edge_flag), 32'(e(4'h1)));
        sw_raw = 4'h2;
        hold(5, 4'h3, "f_fall");
        flag_clr = 4'h1;
        tick();
        check_eq("f_fall_out", 32'(sw_out), 32'h2);
        check_eq("f_fall_pulse", 32'(sw_fall), 32'(e(4'h1)));
        check_eq("f_set_wins", 32'(edge_flag), 32'(e(4'h1)));
        tick();
        flag_clr = 4'h0;
        check_eq("f_cleared", 32'(edge_flag), 32'h0);
        check_eq("f_out_hold", 32'(sw_out), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sw_debounce
